// File: rtl/xrv1_wb_arb.sv
// Writeback arbiter and register scoreboard for the integer register file.
// Merges ALU, LSU and mul/div results into one registered RF write per cycle
// and tracks destinations of outstanding long-latency operations so issue can
// stall on RAW/WAW hazards.
//
// Handshake: a source's result transfers on a rising edge where its valid and
// the matching ready are both high; ready never rises without valid, and the
// ALU is always accepted (it has no ready). Readies are combinational from the
// current valids and the round-robin pointer, and are held low during reset.
module xrv1_wb_arb #(
  parameter int DATA_WIDTH_P    = 32,
  parameter int rf_addr_width_p = 5,
  localparam int rf_size_lp     = 1 << rf_addr_width_p
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alu_wb_valid_i,
  input  logic [rf_addr_width_p-1:0] alu_wb_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    alu_wb_data_i,
  input  logic                       lsu_wb_valid_i,
  output logic                       lsu_wb_ready_o,
  input  logic [rf_addr_width_p-1:0] lsu_wb_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    lsu_wb_data_i,
  input  logic                       md_wb_valid_i,
  output logic                       md_wb_ready_o,
  input  logic [rf_addr_width_p-1:0] md_wb_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    md_wb_data_i,
  input  logic                       sb_set_i,
  input  logic [rf_addr_width_p-1:0] sb_set_addr_i,
  input  logic [rf_addr_width_p-1:0] hz_rs0_addr_i,
  input  logic [rf_addr_width_p-1:0] hz_rs1_addr_i,
  input  logic [rf_addr_width_p-1:0] hz_rd_addr_i,
  output logic                       hz_stall_o,
  output logic                       rd_w_en_o,
  output logic [rf_addr_width_p-1:0] rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]    rd_data_o,
  output logic [rf_size_lp-1:0]      pending_o
);

  // Round-robin pointer: 0 prefers LSU, 1 prefers mul/div.
  logic                       rr_md_q;
  logic                       lsu_grant;
  logic                       md_grant;

  logic                       win_valid;
  logic                       win_long;
  logic [rf_addr_width_p-1:0] win_addr;
  logic [DATA_WIDTH_P-1:0]    win_data;

  logic                       w_en_q;
  logic                       long_q;
  logic [rf_addr_width_p-1:0] addr_q;
  logic [DATA_WIDTH_P-1:0]    data_q;

  logic [rf_size_lp-1:0]      pending_q;
  logic [rf_size_lp-1:0]      pending_d;

  // LSU/MD grant: ALU pre-empts both; on contention the pointer decides.
  always_comb begin
    lsu_grant = 1'b0;
    md_grant  = 1'b0;
    if (!rst_i && !alu_wb_valid_i) begin
      if (lsu_wb_valid_i && (!md_wb_valid_i || !rr_md_q)) begin
        lsu_grant = 1'b1;
      end else if (md_wb_valid_i) begin
        md_grant = 1'b1;
      end
    end
  end

  assign lsu_wb_ready_o = lsu_grant;
  assign md_wb_ready_o  = md_grant;

  // Winner mux; long marks results that retire a scoreboard entry.
  always_comb begin
    win_valid = 1'b0;
    win_long  = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    if (!rst_i && alu_wb_valid_i) begin
      win_valid = 1'b1;
      win_addr  = alu_wb_rd_addr_i;
      win_data  = alu_wb_data_i;
    end else if (lsu_grant) begin
      win_valid = 1'b1;
      win_long  = 1'b1;
      win_addr  = lsu_wb_rd_addr_i;
      win_data  = lsu_wb_data_i;
    end else if (md_grant) begin
      win_valid = 1'b1;
      win_long  = 1'b1;
      win_addr  = md_wb_rd_addr_i;
      win_data  = md_wb_data_i;
    end
  end

  // Pointer flips away from whichever long-latency source was just granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_md_q <= 1'b0;
    end else if (lsu_grant || md_grant) begin
      rr_md_q <= lsu_grant;
    end
  end

  // Output register: x0 writes complete the handshake but never reach the RF,
  // and address/data hold their previous value whenever no write is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_en_q <= 1'b0;
      long_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      w_en_q <= win_valid && (win_addr != '0);
      long_q <= win_long;
      if (win_valid && (win_addr != '0)) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  end

  assign rd_w_en_o = w_en_q;
  assign rd_addr_o = addr_q;
  assign rd_data_o = data_q;

  // Scoreboard next state: the visible long-latency write clears its bit,
  // a new dispatch sets one (set wins on the same address), x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (w_en_q && long_q) begin
      pending_d[addr_q] = 1'b0;
    end
    if (sb_set_i) begin
      pending_d[sb_set_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

  // Hazard: any live operand or destination still awaiting its write.
  always_comb begin
    hz_stall_o = 1'b0;
    if (!rst_i) begin
      hz_stall_o = ((hz_rs0_addr_i != '0) && pending_q[hz_rs0_addr_i]) ||
                   ((hz_rs1_addr_i != '0) && pending_q[hz_rs1_addr_i]) ||
                   ((hz_rd_addr_i  != '0) && pending_q[hz_rd_addr_i]);
    end
  end

endmodule
